pc_redirect_ctrl: RTL
=====================

# pc_redirect_ctrl

Control block that drives the ProgramCounter's pause and write-enable inputs in the MultiCPU fetch stage. It arbitrates PC redirects from the exception unit, the EX-stage branch unit and the ID-stage jump decoder, and merges them with hazard and instruction-memory stalls. It holds a redirect that cannot be applied immediately, issues matching pipeline flushes, and runs a fixed fetch-drain interval after an exception.

## Interface
- EXC_VECTOR, 32'h0000_0004: PC loaded on exception.
- DRAIN_CYCLES, 3: fetch-pause cycles after an exception redirect is applied. Legal range is 1..15.
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_exc_valid  in  1  exception request.
- i_br_valid  in  1  taken branch resolved in EX.
- i_br_target  in  32  branch target.
- i_jmp_valid  in  1  jump decoded in ID.
- i_jmp_target  in  32  jump target.
- i_hazard_stall  in  1  load-use stall from the hazard unit.
- i_imem_ready  in  1  instruction memory can accept a new fetch address.
- o_pc_pause  out  1  to i_ProgramCounter_pause.
- o_pc_we  out  1  to i_ProgramCounter_we.
- o_pc_target  out  32  to i_ProgramCounter_PC.
- o_flush_if  out  1  squash the IF/ID register.
- o_flush_id  out  1  squash the ID/EX register.

## Operation
- States: RUN, HOLD, DRAIN. Reset state is RUN.
- Source priority: exception > branch > jump. The winner is the selected source.

RUN
- If a source is valid and i_imem_ready=1:
  - Assert o_pc_we=1 and drive o_pc_target with the winner's target in the same cycle (combinational).
  - Flushes: o_flush_if=1 for any source; o_flush_id=1 for exception or branch.
  - Next state: DRAIN if the source was an exception, otherwise RUN.
- If a source is valid and i_imem_ready=0:
  - Register the target and source code into the pending register.
  - Assert the flushes in this cycle.
  - Keep o_pc_pause=1 and go to HOLD.
- If no source is valid: o_pc_pause = i_hazard_stall | ~i_imem_ready.

HOLD
- o_pc_pause=1 until i_imem_ready=1.
- When i_imem_ready=1: o_pc_we=1, o_pc_target = pending target, no flush.
  - Next state: DRAIN if the pending source is an exception, otherwise RUN.
- i_br_valid and i_jmp_valid are ignored, because they come from already-flushed instructions.
- i_exc_valid overwrites a pending branch or jump with EXC_VECTOR and asserts o_flush_if and o_flush_id again.

DRAIN
- 4-bit counter loads DRAIN_CYCLES on entry.
- o_pc_pause=1 while the counter is nonzero; the counter decrements each cycle.
- Return to RUN in the cycle after the counter reaches 0.
- All redirect inputs are ignored, including i_exc_valid.

General rules
- Whenever o_pc_we=1, o_pc_pause=0.
- o_pc_target is 0 whenever o_pc_we=0.
- Reset, including mid-HOLD or mid-DRAIN, clears the state to RUN, the counter to 0 and the pending register to 0. The pending redirect is discarded.

## Timing
- Reset values: o_pc_pause=0, o_pc_we=0, o_pc_target=0, o_flush_if=0, o_flush_id=0.
- RUN redirect: zero-cycle decision. The PC holds the target after the next rising edge.
- HOLD release: o_pc_we is asserted in the first cycle with i_imem_ready=1.
- Exception in RUN:
  - cycle 0: we=1.
  - cycles 1..DRAIN_CYCLES: pause=1.
  - cycle DRAIN_CYCLES+1: RUN behaviour.
- Simultaneous exception, branch and jump: only the exception takes effect. Simultaneous branch and jump: the branch wins and o_flush_id=1.
- A redirect takes precedence over i_hazard_stall in the same cycle.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state enum {RUN, HOLD, DRAIN};
  - 2-bit source code {SRC_NONE, SRC_JMP, SRC_BR, SRC_EXC};
  - DRAIN counter width constant.
- Single module with no sub-module. The priority mux and the counter are inline.

## Test plan
- After reset, i_jmp_valid=1, i_jmp_target=32'h100, ready=1 -> o_pc_we=1, o_pc_target=32'h100, o_flush_if=1, o_flush_id=0; the PC reads 32'h100 after the next edge.
- i_br_valid=1 (target 32'h200) and i_jmp_valid=1 (target 32'h300) in the same cycle -> o_pc_target=32'h200, both flushes asserted.
- Branch to 32'h400 with ready=0 for 3 cycles -> flushes in cycle 0, pause=1 for 3 cycles, then we=1 with target 32'h400 in the first ready cycle; a jump offered during HOLD is ignored.
- i_exc_valid=1 with DRAIN_CYCLES=3 -> we=1 with 32'h4, then pause=1 for exactly 3 cycles; an i_exc_valid pulse during DRAIN has no effect.
- i_hazard_stall=1 with no redirect -> pause=1, we=0. Assert rstn=0 mid-HOLD -> all outputs 0 immediately; after release, no pending redirect is applied.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the fetch-stage control blocks.
// Holds the redirect FSM state encoding, the redirect source codes,
// the drain counter width and the pending-redirect payload struct.
package cpu_ctrl_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned DRAIN_CNT_W = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } ctrl_state_e;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_JMP  = 2'd1,
      SRC_BR   = 2'd2,
      SRC_EXC  = 2'd3
   } src_e;

   typedef struct packed {
      src_e            src;
      logic [XLEN-1:0] target;
   } redirect_t;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC redirect controller.
// Arbitrates exception > branch > jump redirects, merges hazard and imem
// stalls into the ProgramCounter pause/write-enable, parks a redirect that
// cannot be applied yet, issues pipeline flushes and pauses fetch for a
// fixed drain interval after an exception.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   i_exc_valid                    exception request
//   i_br_valid / i_br_target       taken branch from EX
//   i_jmp_valid / i_jmp_target     jump from ID
//   i_hazard_stall                 load-use stall
//   i_imem_ready                   imem accepts a new fetch address
//   o_pc_pause, o_pc_we            ProgramCounter controls
//   o_pc_target                    new PC, zero unless o_pc_we
//   o_flush_if, o_flush_id         squash IF/ID, ID/EX
module pc_redirect_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_0004,
   parameter int unsigned     DRAIN_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_exc_valid,
   input  logic            i_br_valid,
   input  logic [XLEN-1:0] i_br_target,
   input  logic            i_jmp_valid,
   input  logic [XLEN-1:0] i_jmp_target,
   input  logic            i_hazard_stall,
   input  logic            i_imem_ready,
   output logic            o_pc_pause,
   output logic            o_pc_we,
   output logic [XLEN-1:0] o_pc_target,
   output logic            o_flush_if,
   output logic            o_flush_id
);

   ctrl_state_e            state_q, state_d;
   redirect_t              pend_q, pend_d;
   logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;

   src_e                   sel_src;
   logic [XLEN-1:0]        sel_target;
   logic                   exc_ovr;
   redirect_t              eff_pend;

   // Priority mux plus the pending redirect as seen this cycle; an exception
   // arriving during HOLD replaces a parked branch or jump.
   always_comb begin
      sel_src    = SRC_NONE;
      sel_target = '0;
      if (i_exc_valid) begin
         sel_src    = SRC_EXC;
         sel_target = EXC_VECTOR;
      end else if (i_br_valid) begin
         sel_src    = SRC_BR;
         sel_target = i_br_target;
      end else if (i_jmp_valid) begin
         sel_src    = SRC_JMP;
         sel_target = i_jmp_target;
      end

      exc_ovr  = i_exc_valid && (pend_q.src != SRC_EXC);
      eff_pend = pend_q;
      if (exc_ovr) begin
         eff_pend.src    = SRC_EXC;
         eff_pend.target = EXC_VECTOR;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Pending redirect and drain counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   // Next-state, pending and counter update
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;

      case (state_q)
         RUN: begin
            if (sel_src != SRC_NONE) begin
               if (i_imem_ready) begin
                  state_d = (sel_src == SRC_EXC) ? DRAIN : RUN;
               end else begin
                  pend_d.src    = sel_src;
                  pend_d.target = sel_target;
                  state_d       = HOLD;
               end
            end
         end
         HOLD: begin
            if (i_imem_ready) begin
               state_d = (eff_pend.src == SRC_EXC) ? DRAIN : RUN;
               pend_d  = '0;
            end else begin
               pend_d = eff_pend;
            end
         end
         DRAIN: begin
            // Leave once the final pause cycle has been counted out.
            if (cnt_q <= DRAIN_CNT_W'(1)) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if ((state_d == DRAIN) && (state_q != DRAIN)) begin
         cnt_d = DRAIN_CNT_W'(DRAIN_CYCLES);
      end else if ((state_q == DRAIN) && (cnt_q != '0)) begin
         cnt_d = cnt_q - DRAIN_CNT_W'(1);
      end
   end

   // Outputs; forced low while reset is asserted so nothing reaches the PC.
   always_comb begin
      o_pc_pause  = 1'b0;
      o_pc_we     = 1'b0;
      o_pc_target = '0;
      o_flush_if  = 1'b0;
      o_flush_id  = 1'b0;

      if (rstn) begin
         case (state_q)
            RUN: begin
               if (sel_src != SRC_NONE) begin
                  o_flush_if = 1'b1;
                  o_flush_id = (sel_src == SRC_EXC) || (sel_src == SRC_BR);
                  if (i_imem_ready) begin
                     o_pc_we     = 1'b1;
                     o_pc_target = sel_target;
                  end else begin
                     o_pc_pause = 1'b1;
                  end
               end else begin
                  o_pc_pause = i_hazard_stall | ~i_imem_ready;
               end
            end
            HOLD: begin
               if (exc_ovr) begin
                  o_flush_if = 1'b1;
                  o_flush_id = 1'b1;
               end
               if (i_imem_ready) begin
                  o_pc_we     = 1'b1;
                  o_pc_target = eff_pend.target;
               end else begin
                  o_pc_pause = 1'b1;
               end
            end
            DRAIN: begin
               o_pc_pause = (cnt_q != '0);
            end
            default: begin
               o_pc_pause = 1'b0;
            end
         endcase
      end
   end

endmodule
